spi_tx_frame_ctrl: RTL and testbench

- Frame sequencer that drives the SPI transmit shifter.
- Accepts a frame command (word count, word length, CRC append) and pulls 32-bit payload words from a requester through a one-word staging register.
- Presents txe, data, length and CRC-select to the shifter in each word-load slot, then reports frame completion.
- Sits between the host/DMA-side word source and the SPI TX shift datapath.

---
 rtl/spi_tx_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_spi_tx_frame_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_tx_frame_ctrl.sv
// spi_tx_frame_ctrl: frame sequencer feeding an SPI transmit shifter.
// Accepts a frame command, pulls payload words through a one-word staging
// register and presents load enable, data, word length and CRC select to the
// shifter in each word-load slot. An optional CRC slot follows the payload.
// A drain slot then lets the last word finish before completion is reported.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   frame command handshake (cmd_words, cmd_len, cmd_crc_en)
//   wr_valid/wr_ready     payload word handshake (wr_data)
//   abort                 terminate the current frame
//   load_slot             shifter word-boundary strobe
//   txe, tx_data, tx_len, tx_cnt_max   shifter load interface (txe active low)
//   crc_clr               one-cycle CRC clear after command accept
//   busy, frame_done, frame_aborted, underrun, words_sent   status
module spi_tx_frame_ctrl #(
  parameter int unsigned WCNT_W  = 8,
  parameter int unsigned MIN_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WCNT_W-1:0] cmd_words,
  input  logic [4:0]        cmd_len,
  input  logic              cmd_crc_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  input  logic              abort,
  input  logic              load_slot,
  output logic              txe,
  output logic [31:0]       tx_data,
  output logic [4:0]        tx_len,
  output logic              tx_cnt_max,
  output logic              crc_clr,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_aborted,
  output logic              underrun,
  output logic [WCNT_W:0]   words_sent
);

  localparam int unsigned CW = WCNT_W + 1;
  localparam logic [4:0] MinLen = 5'(MIN_LEN);
  localparam logic [CW-1:0] FullCnt = {1'b1, {WCNT_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StData, StCrc, StDrain} state_e;

  state_e        state_q, state_d;
  logic [31:0]   stage_q, stage_d;
  logic          stage_full_q, stage_full_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] words_sent_q, words_sent_d;
  logic [4:0]    len_q, len_d;
  logic          crc_en_q, crc_en_d;
  logic          aborted_q, aborted_d;
  logic          underrun_q, underrun_d;
  logic          crc_clr_q, crc_clr_d;

  logic cmd_fire, consume, fetch_more, wr_fire, in_data;

  always_comb begin
    in_data    = (state_q == StData);
    cmd_fire   = (state_q == StIdle) & cmd_valid & ~rst;
    consume    = in_data & load_slot & stage_full_q & ~abort;
    // Words still to fetch = remaining minus the one already staged.
    fetch_more = remaining_q > CW'(stage_full_q);
    wr_ready   = in_data & ~abort & ~rst & (~stage_full_q | consume) & fetch_more;
    wr_fire    = wr_valid & wr_ready;
    cmd_ready  = (state_q == StIdle) & ~rst;
    frame_done    = (state_q == StDrain) & load_slot & ~rst;
    frame_aborted = frame_done & (aborted_q | abort);
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    remaining_d  = remaining_q;
    words_sent_d = words_sent_q;
    len_d        = len_q;
    crc_en_d     = crc_en_q;
    aborted_d    = aborted_q;
    underrun_d   = underrun_q;
    crc_clr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          remaining_d  = (cmd_words == '0) ? FullCnt : {1'b0, cmd_words};
          len_d        = (cmd_len < MinLen) ? MinLen : cmd_len;
          crc_en_d     = cmd_crc_en;
          words_sent_d = '0;
          underrun_d   = 1'b0;
          aborted_d    = 1'b0;
          stage_full_d = 1'b0;
          crc_clr_d    = 1'b1;
          state_d      = StData;
        end
      end
      StData: begin
        if (abort) begin
          // Abort wins over a coincident slot: the staged word is dropped uncounted.
          stage_full_d = 1'b0;
          aborted_d    = 1'b1;
          state_d      = StDrain;
        end else begin
          if (load_slot) begin
            if (stage_full_q) begin
              remaining_d  = remaining_q - CW'(1);
              words_sent_d = words_sent_q + CW'(1);
              if (remaining_q == CW'(1)) state_d = crc_en_q ? StCrc : StDrain;
            end else begin
              underrun_d = 1'b1;
            end
          end
          stage_full_d = (stage_full_q & ~consume) | wr_fire;
          if (wr_fire) stage_d = wr_data;
        end
      end
      StCrc: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDrain;
        end else if (load_slot) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) aborted_d = 1'b1;
        if (load_slot) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      remaining_q  <= '0;
      words_sent_q <= '0;
      len_q        <= MinLen;
      crc_en_q     <= 1'b0;
      aborted_q    <= 1'b0;
      underrun_q   <= 1'b0;
      crc_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      remaining_q  <= remaining_d;
      words_sent_q <= words_sent_d;
      len_q        <= len_d;
      crc_en_q     <= crc_en_d;
      aborted_q    <= aborted_d;
      underrun_q   <= underrun_d;
      crc_clr_q    <= crc_clr_d;
    end
  end

  // Shifter-facing outputs come from registered state only.
  always_comb begin
    txe        = in_data ? ~stage_full_q : 1'b1;
    tx_data    = (in_data & stage_full_q) ? stage_q : 32'h0;
    tx_len     = len_q;
    tx_cnt_max = (state_q == StCrc);
    crc_clr    = crc_clr_q;
    busy       = (state_q != StIdle);
    underrun   = underrun_q;
    words_sent = words_sent_q;
  end

endmodule

// File: tb/tb_spi_tx_frame_ctrl.sv
// Randomized bench for spi_tx_frame_ctrl against a queue-based frame model.
module tb_spi_tx_frame_ctrl;

  localparam int unsigned WW   = 2;
  localparam int unsigned MINL = 8;
  localparam int          NCYC = 6000;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_crc_en;
  logic [WW-1:0] cmd_words;
  logic [4:0]    cmd_len;
  logic          wr_valid, wr_ready;
  logic [31:0]   wr_data;
  logic          abort, load_slot;
  logic          txe, tx_cnt_max, crc_clr, busy, frame_done, frame_aborted, underrun;
  logic [31:0]   tx_data;
  logic [4:0]    tx_len;
  logic [WW:0]   words_sent;

  spi_tx_frame_ctrl #(.WCNT_W(WW), .MIN_LEN(MINL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_words(cmd_words),
    .cmd_len(cmd_len), .cmd_crc_en(cmd_crc_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .abort(abort), .load_slot(load_slot),
    .txe(txe), .tx_data(tx_data), .tx_len(tx_len), .tx_cnt_max(tx_cnt_max),
    .crc_clr(crc_clr), .busy(busy), .frame_done(frame_done),
    .frame_aborted(frame_aborted), .underrun(underrun), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame model: a frame is payload_left words, then an optional CRC slot,
  // then a drain slot. Staged words live in a queue.
  bit          in_frame, drain, crc_left, aborted_m, underrun_m, crc_clr_m;
  int          payload_left, sent;
  logic [4:0]  len_m;
  logic [31:0] q[$];

  function automatic void model_reset();
    in_frame = 0; drain = 0; crc_left = 0; aborted_m = 0; underrun_m = 0;
    crc_clr_m = 0; payload_left = 0; sent = 0; len_m = 5'(MINL);
    q.delete();
  endfunction

  bit data_ph, crc_ph, e_wr_ready, e_done, e_abt;

  initial begin
    clk = 0; rst = 1; cmd_valid = 0; cmd_words = '0; cmd_len = '0; cmd_crc_en = 0;
    wr_valid = 0; wr_data = '0; abort = 0; load_slot = 0;
    model_reset();
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      rst        = (i < 3) || ($urandom_range(0, 249) == 0);
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_words  = WW'($urandom_range(0, 3));
      cmd_len    = 5'($urandom_range(0, 31));
      cmd_crc_en = 1'($urandom_range(0, 1));
      wr_valid   = 1'($urandom_range(0, 1));
      wr_data    = $urandom;
      load_slot  = ($urandom_range(0, 2) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      @(negedge clk);

      data_ph    = in_frame && !drain && payload_left > 0;
      crc_ph     = in_frame && !drain && payload_left == 0 && crc_left;
      e_wr_ready = !rst && data_ph && !abort && (q.size() == 0 || load_slot)
                   && (payload_left > q.size());
      e_done     = !rst && in_frame && drain && load_slot;
      e_abt      = e_done && (aborted_m || abort);

      if (i >= 1) begin
        check_eq("cmd_ready", 32'(cmd_ready), 32'(!rst && !in_frame));
        check_eq("busy", 32'(busy), 32'(in_frame));
        check_eq("wr_ready", 32'(wr_ready), 32'(e_wr_ready));
        check_eq("txe", 32'(txe), 32'(data_ph ? (q.size() == 0) : 1'b1));
        check_eq("tx_data", tx_data, (data_ph && q.size() > 0) ? q[0] : 32'h0);
        check_eq("tx_len", 32'(tx_len), 32'(len_m));
        check_eq("tx_cnt_max", 32'(tx_cnt_max), 32'(crc_ph));
        check_eq("crc_clr", 32'(crc_clr), 32'(crc_clr_m));
        check_eq("frame_done", 32'(frame_done), 32'(e_done));
        check_eq("frame_aborted", 32'(frame_aborted), 32'(e_abt));
        check_eq("underrun", 32'(underrun), 32'(underrun_m));
        check_eq("words_sent", 32'(words_sent), 32'(sent));
      end

      if (rst) begin
        model_reset();
      end else begin
        crc_clr_m = 0;
        if (!in_frame) begin
          if (cmd_valid) begin
            in_frame     = 1;
            drain        = 0;
            aborted_m    = 0;
            underrun_m   = 0;
            sent         = 0;
            crc_clr_m    = 1;
            payload_left = (cmd_words == 0) ? (1 << WW) : int'(cmd_words);
            crc_left     = cmd_crc_en;
            len_m        = (cmd_len < 5'(MINL)) ? 5'(MINL) : cmd_len;
            q.delete();
          end
        end else if (drain && load_slot) begin
          in_frame = 0;
          drain    = 0;
        end else if (abort) begin
          q.delete();
          aborted_m    = 1;
          drain        = 1;
          crc_left     = 0;
          payload_left = 0;
        end else if (crc_ph) begin
          if (load_slot) begin
            crc_left = 0;
            drain    = 1;
          end
        end else if (data_ph) begin
          if (load_slot) begin
            if (q.size() > 0) begin
              void'(q.pop_front());
              sent++;
              payload_left--;
              if (payload_left == 0 && !crc_left) drain = 1;
            end else begin
              underrun_m = 1;
            end
          end
          if (wr_valid && e_wr_ready) q.push_back(wr_data);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
